// File: rtl/output_port_arbiter_pkg.sv
// Shared types and helpers for the per-output request/CTS arbiter.
package exanet_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int VC_NUM    = 3;
  localparam int PRIO_NUM  = 2;
  localparam int INPUT_NUM = 4;
  localparam int IN_W      = $clog2(INPUT_NUM);
  localparam int K_W       = $clog2(VC_NUM * PRIO_NUM);

  function automatic int CLASS_IDX(input int p, input int v, input int vc_num);
    return p * vc_num + v;
  endfunction

  // Width of an index into n items, never zero.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/CTS bundle between input VC request logic (master) and one output arbiter (slave).
interface output_port_arbiter_if
  import exanet_arb_pkg::*;
#(
  parameter int vc_num    = VC_NUM,
  parameter int prio_num  = PRIO_NUM,
  parameter int input_num = INPUT_NUM
);
  localparam int NK = vc_num * prio_num;
  localparam int IW = clog2_min1(input_num);
  localparam int KW = clog2_min1(NK);

  logic [input_num-1:0][NK-1:0] i_request;
  logic [NK-1:0]                i_credit_avail;
  logic                         i_last;
  logic                         o_cts;
  logic [IW-1:0]                o_selected_input;
  logic [KW-1:0]                o_selected_vc;
  logic                         o_busy;
  logic                         o_timeout_err;

  modport slave (
    input  i_request, i_credit_avail, i_last,
    output o_cts, o_selected_input, o_selected_vc, o_busy, o_timeout_err
  );

  modport master (
    output i_request, i_credit_avail, i_last,
    input  o_cts, o_selected_input, o_selected_vc, o_busy, o_timeout_err
  );
endinterface

// File: rtl/output_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req_i at or after ptr_i, wrapping at N.
module rr_pick
  import exanet_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] gnt_idx_o,
  output logic          any_o
);
  int idx;

  // Scan offsets from far to near so the closest request to ptr_i is written last.
  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    for (int j = N - 1; j >= 0; j--) begin
      idx = int'(ptr_i) + j;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        gnt_idx_o = PW'(idx);
        any_o     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_port_arbiter.sv
// Output-port arbiter: priority + VC round-robin class pick, input round-robin, grant held to last beat.
// Optional BUSY watchdog enabled by defining OUTPUT_ARB_TIMEOUT_EN.
module output_port_arbiter
  import exanet_arb_pkg::*;
#(
  parameter int vc_num         = VC_NUM,
  parameter int prio_num       = PRIO_NUM,
  parameter int input_num      = INPUT_NUM,
  parameter int timeout_cycles = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  output_port_arbiter_if.slave bus
);
  localparam int NK = vc_num * prio_num;
  localparam int IW = clog2_min1(input_num);
  localparam int KW = clog2_min1(NK);
  localparam int VW = clog2_min1(vc_num);
  localparam int PW = clog2_min1(prio_num);

  arb_state_t state_q, state_d;
  logic [IW-1:0] sel_in_q, sel_in_d;
  logic [KW-1:0] sel_k_q, sel_k_d;
  logic [PW-1:0] sel_p_q, sel_p_d;
  logic [VW-1:0] sel_v_q, sel_v_d;
  logic [prio_num-1:0][VW-1:0] vc_ptr_q, vc_ptr_d;
  logic [NK-1:0][IW-1:0]       in_ptr_q, in_ptr_d;
`ifdef OUTPUT_ARB_TIMEOUT_EN
  logic        err_q, err_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

  logic [NK-1:0]               elig;
  logic [prio_num-1:0][VW-1:0] vgnt;
  logic [prio_num-1:0]         vany;
  logic [PW-1:0]               pick_p;
  logic [VW-1:0]               pick_v;
  logic [KW-1:0]               pick_k;
  logic                        have_cls;
  logic [input_num-1:0]        in_req;
  logic [IW-1:0]               pick_in;
  logic                        in_any;
  logic                        have;
  logic                        sel_req;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < input_num; i++)
        elig[k] = elig[k] | bus.i_request[i][k];
    elig = elig & bus.i_credit_avail;
  end

  for (genvar p = 0; p < prio_num; p++) begin : g_vc
    rr_pick #(.N(vc_num), .PW(VW)) u_vc_pick (
      .req_i    (elig[p*vc_num +: vc_num]),
      .ptr_i    (vc_ptr_q[p]),
      .gnt_idx_o(vgnt[p]),
      .any_o    (vany[p])
    );
  end

  // Highest priority level with an eligible class wins (last writer in the loop).
  always_comb begin
    pick_p   = '0;
    have_cls = 1'b0;
    for (int p = 0; p < prio_num; p++) begin
      if (vany[p]) begin
        pick_p   = PW'(p);
        have_cls = 1'b1;
      end
    end
    pick_v = vgnt[pick_p];
    pick_k = KW'(CLASS_IDX(int'(pick_p), int'(pick_v), vc_num));
    for (int i = 0; i < input_num; i++) in_req[i] = bus.i_request[i][pick_k];
  end

  rr_pick #(.N(input_num), .PW(IW)) u_in_pick (
    .req_i    (in_req),
    .ptr_i    (in_ptr_q[pick_k]),
    .gnt_idx_o(pick_in),
    .any_o    (in_any)
  );

  assign have    = have_cls & in_any;
  assign sel_req = bus.i_request[sel_in_q][sel_k_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB;
      sel_in_q  <= '0;
      sel_k_q   <= '0;
      sel_p_q   <= '0;
      sel_v_q   <= '0;
      vc_ptr_q  <= '0;
      in_ptr_q  <= '0;
`ifdef OUTPUT_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_in_q  <= sel_in_d;
      sel_k_q   <= sel_k_d;
      sel_p_q   <= sel_p_d;
      sel_v_q   <= sel_v_d;
      vc_ptr_q  <= vc_ptr_d;
      in_ptr_q  <= in_ptr_d;
`ifdef OUTPUT_ARB_TIMEOUT_EN
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_in_d = sel_in_q;
    sel_k_d  = sel_k_q;
    sel_p_d  = sel_p_q;
    sel_v_d  = sel_v_q;
    vc_ptr_d = vc_ptr_q;
    in_ptr_d = in_ptr_q;
`ifdef OUTPUT_ARB_TIMEOUT_EN
    err_d     = err_q;
    tmo_cnt_d = tmo_cnt_q;
`endif
    unique case (state_q)
      ARB: begin
        if (have) begin
          sel_in_d = pick_in;
          sel_k_d  = pick_k;
          sel_p_d  = pick_p;
          sel_v_d  = pick_v;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // A request withdrawn during GRANT forfeits the slot without touching fairness state.
        if (sel_req) begin
          in_ptr_d[sel_k_q] = (sel_in_q == IW'(input_num - 1)) ? '0 : sel_in_q + 1'b1;
          vc_ptr_d[sel_p_q] = (sel_v_q == VW'(vc_num - 1)) ? '0 : sel_v_q + 1'b1;
          state_d = bus.i_last ? ARB : BUSY;
`ifdef OUTPUT_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          state_d = ARB;
        end
      end
      BUSY: begin
        if (bus.i_last) begin
          state_d = ARB;
        end
`ifdef OUTPUT_ARB_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
          if (tmo_cnt_q + 16'd1 >= 16'(timeout_cycles)) begin
            err_d   = 1'b1;
            state_d = ARB;
          end
        end
`endif
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    bus.o_cts            = (state_q == GRANT) && sel_req;
    bus.o_busy           = (state_q != ARB);
    bus.o_selected_input = sel_in_q;
    bus.o_selected_vc    = sel_k_q;
`ifdef OUTPUT_ARB_TIMEOUT_EN
    bus.o_timeout_err    = err_q;
`else
    bus.o_timeout_err    = 1'b0;
`endif
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed + randomized bench for output_port_arbiter against a spec-level reference model.
module tb_output_port_arbiter;
  localparam int VC = 3;
  localparam int PR = 2;
  localparam int IN = 4;
  localparam int NK = VC * PR;
  localparam int T  = 8;

  typedef logic [IN-1:0][NK-1:0] req_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.vc_num(VC), .prio_num(PR), .input_num(IN)) bus ();

  output_port_arbiter #(
    .vc_num(VC), .prio_num(PR), .input_num(IN), .timeout_cycles(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: 0 = idle/arbitrating, 1 = granted, 2 = streaming packet
  int   m_st  = 0;
  int   m_in  = 0;
  int   m_k   = 0;
  int   m_cnt = 0;
  logic m_err = 1'b0;
  int   vcp[PR];
  int   inp[NK];

  req_t            cur_r;
  logic [NK-1:0]   cur_c;
  logic            cur_l;
  logic            cur_rst;
  logic [31:0]     s_cts, s_busy, s_in, s_vc, s_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic req_t one(input int i, input int k);
    req_t r;
    r = '0;
    r[i][k] = 1'b1;
    return r;
  endfunction

  task automatic drv(input req_t r, input logic [NK-1:0] c, input logic l, input logic rs);
    cur_r = r; cur_c = c; cur_l = l; cur_rst = rs;
    bus.i_request = r; bus.i_credit_avail = c; bus.i_last = l; reset = rs;
  endtask

  task automatic model_step;
    bit found;
    int kk, ii, v;
    found = 0; kk = 0; ii = 0;
    if (cur_rst) begin
      m_st = 0; m_in = 0; m_k = 0; m_cnt = 0; m_err = 1'b0;
      foreach (vcp[p]) vcp[p] = 0;
      foreach (inp[k]) inp[k] = 0;
    end else begin
      case (m_st)
        0: begin
          for (int p = PR - 1; p >= 0 && !found; p--)
            for (int o = 0; o < VC && !found; o++) begin
              v = (vcp[p] + o) % VC;
              if (cur_c[p*VC + v] && (|cur_r[0][p*VC+v] || |cur_r[1][p*VC+v] ||
                                       |cur_r[2][p*VC+v] || |cur_r[3][p*VC+v])) begin
                found = 1; kk = p * VC + v;
              end
            end
          if (found) begin
            for (int o = IN - 1; o >= 0; o--)
              if (cur_r[(inp[kk] + o) % IN][kk]) ii = (inp[kk] + o) % IN;
            m_in = ii; m_k = kk; m_st = 1;
          end
        end
        1: begin
          if (cur_r[m_in][m_k]) begin
            inp[m_k] = (m_in + 1) % IN;
            vcp[m_k / VC] = (m_k % VC + 1) % VC;
            m_st = cur_l ? 0 : 2;
            m_cnt = 0;
          end else m_st = 0;
        end
        default: begin
          if (cur_l) m_st = 0;
`ifdef OUTPUT_ARB_TIMEOUT_EN
          else begin
            m_cnt++;
            if (m_cnt >= T) begin m_err = 1'b1; m_st = 0; end
          end
`endif
        end
      endcase
    end
  endtask

  task automatic tick;
    @(negedge clk);
    s_cts  = 32'(bus.o_cts);
    s_busy = 32'(bus.o_busy);
    s_in   = 32'(bus.o_selected_input);
    s_vc   = 32'(bus.o_selected_vc);
    s_err  = 32'(bus.o_timeout_err);
    chk("cts",  s_cts,  32'((m_st == 1) && cur_r[m_in][m_k]));
    chk("busy", s_busy, 32'(m_st != 0));
    chk("sel_input", s_in, 32'(m_in));
    chk("sel_vc", s_vc, 32'(m_k));
    chk("timeout_err", s_err, 32'(m_err));
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_t all2, rr;
    logic [NK-1:0] cc;
    foreach (vcp[p]) vcp[p] = 0;
    foreach (inp[k]) inp[k] = 0;

    // Reset, then a single packet from in0 on class 0
    drv('0, '1, 1'b0, 1'b1); tick(); tick();
    chk("rst_busy", s_busy, 0); chk("rst_in", s_in, 0); chk("rst_vc", s_vc, 0);
    drv(one(0, 0), '1, 1'b0, 1'b0); tick(); chk("t1_arb_cts", s_cts, 0);
    tick(); chk("t1_cts", s_cts, 1); chk("t1_in", s_in, 0); chk("t1_vc", s_vc, 0);
    tick(); chk("t1_busy", s_busy, 1); chk("t1_busy_cts", s_cts, 0);
    drv(one(0, 0), '1, 1'b1, 1'b0); tick();
    drv('0, '1, 1'b0, 1'b0); tick(); chk("t1_idle", s_busy, 0);

    // Four inputs on class 2, single-beat packets: strict rotation
    all2 = one(0, 2) | one(1, 2) | one(2, 2) | one(3, 2);
    drv(all2, '1, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) begin
      tick(); chk("t2_gap", s_cts, 0);
      tick(); chk("t2_cts", s_cts, 1); chk($sformatf("t2_in%0d", n), s_in, n % IN);
    end

    // Priority 1 beats priority 0
    drv(one(1, 1) | one(2, 4), '1, 1'b0, 1'b0); tick(); tick();
    chk("t3_in", s_in, 2); chk("t3_vc", s_vc, 4); chk("t3_cts", s_cts, 1);
    drv(one(1, 1) | one(2, 4), '1, 1'b1, 1'b0); tick();
    drv(one(1, 1), '1, 1'b1, 1'b0); tick(); tick();
    chk("t3b_in", s_in, 1); chk("t3b_vc", s_vc, 1); chk("t3b_cts", s_cts, 1);

    // Withdrawn request in GRANT leaves in_ptr[5] at 3
    drv(one(2, 5), '1, 1'b1, 1'b0); tick(); tick();
    drv(one(3, 5), '1, 1'b0, 1'b0); tick();
    drv('0, '1, 1'b0, 1'b0); tick(); chk("t4_cts", s_cts, 0); chk("t4_gbusy", s_busy, 1);
    tick(); chk("t4_busy", s_busy, 0);
    drv(one(0, 5) | one(3, 5), '1, 1'b1, 1'b0); tick(); tick(); chk("t4_in", s_in, 3);

    // Credit gating
    cc = 6'b110111;
    drv(one(0, 3), cc, 1'b0, 1'b0); tick(); tick();
    chk("t5_nocts", s_cts, 0); chk("t5_nobusy", s_busy, 0);
    drv(one(0, 3), '1, 1'b1, 1'b0); tick(); chk("t5_arb", s_cts, 0);
    tick(); chk("t5_cts", s_cts, 1); chk("t5_vc", s_vc, 3);
    drv('0, '1, 1'b0, 1'b0); tick(); chk("t5_idle", s_busy, 0);

    // Reset mid-packet drops the grant
    drv(one(1, 0), '1, 1'b0, 1'b0); tick(); tick(); tick();
    drv(one(1, 0), '1, 1'b0, 1'b1); tick();
    drv('0, '1, 1'b0, 1'b0); tick();
    chk("rst_mid_busy", s_busy, 0); chk("rst_mid_in", s_in, 0);

`ifdef OUTPUT_ARB_TIMEOUT_EN
    drv(one(0, 0), '1, 1'b0, 1'b0); tick(); tick();
    for (int n = 0; n < T; n++) tick();
    tick(); chk("t6_err", s_err, 1); chk("t6_arb", s_busy, 0);
    tick(); tick();
    drv(one(0, 0), '1, 1'b0, 1'b1); tick();
    drv('0, '1, 1'b0, 1'b0); tick();
    chk("t6_rst_err", s_err, 0); chk("t6_rst_busy", s_busy, 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rr = '0;
      for (int i = 0; i < IN; i++)
        for (int k = 0; k < NK; k++) rr[i][k] = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NK; k++) cc[k] = ($urandom_range(0, 4) != 0);
      drv(rr, cc, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
